// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } ctrl_state_t;

    localparam int unsigned DRAIN_DEPTH_DEFAULT = 3;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with a 0..3 increment per cycle; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;
    logic [W:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + (W+1)'(inc);
        count_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage-register load/flush sequencer: memory stalls, load-use bubbles, branch
// squashes, halt drain, and stall/bubble performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DRAIN_DEPTH = DRAIN_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_busy,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             id_ex_is_load,
    input  logic [4:0]       id_ex_rd,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic             ex_br_taken,
    input  logic             halt_id,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int unsigned DW = $clog2(DRAIN_DEPTH + 1);

    ctrl_state_t   state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          mem_stall;
    logic          load_use;
    logic [1:0]    stall_inc;
    logic [1:0]    bubble_inc;

    assign mem_stall = (imem_busy & ~imem_resp) | (dmem_req & ~dmem_resp);
    assign load_use  = id_ex_is_load & (id_ex_rd != 5'd0) &
                       ((if_id_use_rs1 & (if_id_rs1 == id_ex_rd)) |
                        (if_id_use_rs2 & (if_id_rs2 == id_ex_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                // A halt sitting behind a taken branch is on the wrong path.
                if (!mem_stall && halt_id && !ex_br_taken) begin
                    state_d = DRAIN;
                    drain_d = DW'(DRAIN_DEPTH);
                end
            end
            DRAIN: begin
                if (!mem_stall) begin
                    if (drain_q == DW'(1)) begin
                        state_d = HALTED;
                    end
                    drain_d = drain_q - DW'(1);
                end
            end
            HALTED:  ;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        halted      = 1'b0;
        stall_inc   = 2'd0;
        bubble_inc  = 2'd0;
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        stall_inc = 2'd1;
                    end else if (ex_br_taken) begin
                        {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = '1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        bubble_inc  = 2'd2;
                    end else if (load_use) begin
                        {load_id_ex, load_ex_mem, load_mem_wb} = '1;
                        flush_id_ex = 1'b1;
                        bubble_inc  = 2'd1;
                    end else begin
                        {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = '1;
                    end
                end
                DRAIN: begin
                    // Front end is frozen; only ID/EX onward keeps moving.
                    if (mem_stall) begin
                        stall_inc = 2'd1;
                    end else if (load_use) begin
                        {load_id_ex, load_ex_mem, load_mem_wb} = '1;
                        flush_id_ex = 1'b1;
                        bubble_inc  = 2'd1;
                    end else begin
                        {load_id_ex, load_ex_mem, load_mem_wb} = '1;
                    end
                end
                HALTED:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_inc != 2'd0),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bubble_inc != 2'd0),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: combinational vector table in RUN plus
// hand sequences for counters, drain, squash, reset and saturation.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             imem_busy, imem_resp, dmem_req, dmem_resp;
    logic             id_ex_is_load;
    logic [4:0]       id_ex_rd, if_id_rs1, if_id_rs2;
    logic             if_id_use_rs1, if_id_use_rs2, ex_br_taken, halt_id;
    logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             flush_if_id, flush_id_ex, halted;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;
    logic [4:0]       loads;
    logic [1:0]       flushes;

    int checks   = 0;
    int failures = 0;

    assign loads   = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    assign flushes = {flush_if_id, flush_id_ex};

    pipeline_ctrl #(
        .CNT_W       (CNT_W),
        .DRAIN_DEPTH (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_busy     (imem_busy),
        .imem_resp     (imem_resp),
        .dmem_req      (dmem_req),
        .dmem_resp     (dmem_resp),
        .id_ex_is_load (id_ex_is_load),
        .id_ex_rd      (id_ex_rd),
        .if_id_rs1     (if_id_rs1),
        .if_id_rs2     (if_id_rs2),
        .if_id_use_rs1 (if_id_use_rs1),
        .if_id_use_rs2 (if_id_use_rs2),
        .ex_br_taken   (ex_br_taken),
        .halt_id       (halt_id),
        .load_pc       (load_pc),
        .load_if_id    (load_if_id),
        .load_id_ex    (load_id_ex),
        .load_ex_mem   (load_ex_mem),
        .load_mem_wb   (load_mem_wb),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       ib, ir, dq, dr, ld;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br;
        logic [4:0] exp_loads;
        logic [1:0] exp_flush;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        imem_busy = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        id_ex_is_load = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
        if_id_use_rs1 = 0; if_id_use_rs2 = 0; ex_br_taken = 0; halt_id = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #2;
        rst_n = 1;
        #1;
    endtask

    initial begin
        //        ib ir dq dr ld rd rs1 rs2 u1 u2 br  loads     flush
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00};
        vecs[2]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00};
        vecs[3]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'b00};
        vecs[4]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 2'b11};
        vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 2'b00};
        vecs[7]  = '{0, 0, 0, 0, 1, 7, 7, 0, 1, 0, 0, 5'b00111, 2'b01};
        vecs[8]  = '{0, 0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 5'b11111, 2'b00};
        vecs[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 5'b11111, 2'b00};
        vecs[10] = '{0, 0, 0, 0, 0, 9, 9, 9, 1, 1, 0, 5'b11111, 2'b00};
        vecs[11] = '{0, 0, 0, 0, 1, 12, 3, 12, 1, 1, 0, 5'b00111, 2'b01};
        vecs[12] = '{0, 0, 0, 0, 1, 12, 12, 0, 1, 0, 1, 5'b11111, 2'b11};
        vecs[13] = '{0, 0, 1, 0, 1, 12, 12, 0, 1, 0, 0, 5'b00000, 2'b00};

        idle();
        rst_n = 0;
        #12;
        check("reset_loads", 32'(loads), 0);
        check("reset_flush", 32'(flushes), 0);
        check("reset_halted", 32'(halted), 0);
        rst_n = 1;
        #1;
        check("post_reset_loads", 32'(loads), 32'h1f);
        check("post_reset_stall", 32'(stall_cnt), 0);
        check("post_reset_bubble", 32'(bubble_cnt), 0);

        for (int i = 0; i < 14; i++) begin
            imem_busy = vecs[i].ib; imem_resp = vecs[i].ir;
            dmem_req = vecs[i].dq; dmem_resp = vecs[i].dr;
            id_ex_is_load = vecs[i].ld; id_ex_rd = vecs[i].rd;
            if_id_rs1 = vecs[i].rs1; if_id_rs2 = vecs[i].rs2;
            if_id_use_rs1 = vecs[i].u1; if_id_use_rs2 = vecs[i].u2;
            ex_br_taken = vecs[i].br; halt_id = 0;
            #1;
            check($sformatf("vec%0d_loads", i), 32'(loads), 32'(vecs[i].exp_loads));
            check($sformatf("vec%0d_flush", i), 32'(flushes), 32'(vecs[i].exp_flush));
            check($sformatf("vec%0d_halted", i), 32'(halted), 0);
            tick();
        end

        // Load-use bubble count, then the same compare against x0.
        do_reset();
        id_ex_is_load = 1; id_ex_rd = 5; if_id_use_rs2 = 1; if_id_rs2 = 5;
        #1;
        check("lu_loads", 32'(loads), 32'h07);
        check("lu_flush", 32'(flushes), 32'h1);
        tick();
        check("lu_bubble", 32'(bubble_cnt), 1);
        id_ex_rd = 0; if_id_rs2 = 0;
        #1;
        check("lu_x0_loads", 32'(loads), 32'h1f);
        check("lu_x0_flush", 32'(flushes), 0);
        tick();
        check("lu_x0_bubble", 32'(bubble_cnt), 1);

        // Data stall with a branch held in EX, then the redirect.
        do_reset();
        dmem_req = 1; ex_br_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("ms_loads%0d", i), 32'(loads), 0);
            check($sformatf("ms_flush%0d", i), 32'(flushes), 0);
            tick();
        end
        check("ms_stall_cnt", 32'(stall_cnt), 4);
        check("ms_bubble_pre", 32'(bubble_cnt), 0);
        dmem_resp = 1;
        #1;
        check("br_loads", 32'(loads), 32'h1f);
        check("br_flush", 32'(flushes), 32'h3);
        tick();
        check("br_bubble", 32'(bubble_cnt), 2);
        check("br_stall_cnt", 32'(stall_cnt), 4);

        // Halt drain: 3 advancing cycles plus one imem stall.
        do_reset();
        halt_id = 1;
        #1;
        check("halt_entry_loads", 32'(loads), 32'h1f);
        tick();
        idle();
        #1;
        check("drain1_loads", 32'(loads), 32'h07);
        check("drain1_flush", 32'(flushes), 0);
        tick();
        check("drain1_halted", 32'(halted), 0);
        imem_busy = 1;
        #1;
        check("drain2_loads", 32'(loads), 0);
        tick();
        check("drain2_halted", 32'(halted), 0);
        check("drain2_stall", 32'(stall_cnt), 1);
        idle();
        id_ex_is_load = 1; id_ex_rd = 4; if_id_use_rs1 = 1; if_id_rs1 = 4;
        #1;
        check("drain3_loads", 32'(loads), 32'h07);
        check("drain3_flush", 32'(flushes), 32'h1);
        tick();
        check("drain3_halted", 32'(halted), 0);
        check("drain3_bubble", 32'(bubble_cnt), 1);
        idle();
        tick();
        check("drain4_halted", 32'(halted), 1);
        check("halted_loads", 32'(loads), 0);
        check("halted_flush", 32'(flushes), 0);
        imem_busy = 1; ex_br_taken = 1;
        tick();
        check("halted_frozen_stall", 32'(stall_cnt), 1);
        check("halted_frozen_bubble", 32'(bubble_cnt), 1);
        check("halted_sticky", 32'(halted), 1);
        rst_n = 0;
        #1;
        check("halt_reset_halted", 32'(halted), 0);
        check("halt_reset_loads", 32'(loads), 0);
        idle();
        rst_n = 1;
        #1;
        check("halt_release_loads", 32'(loads), 32'h1f);
        check("halt_release_stall", 32'(stall_cnt), 0);

        // Halt behind a taken branch is ignored.
        do_reset();
        halt_id = 1; ex_br_taken = 1;
        #1;
        check("squash_flush", 32'(flushes), 32'h3);
        tick();
        idle();
        #1;
        check("squash_loads", 32'(loads), 32'h1f);
        tick();
        tick();
        tick();
        tick();
        check("squash_halted", 32'(halted), 0);

        // Saturation at 2^CNT_W-1, including +2 from max-1.
        do_reset();
        imem_busy = 1;
        repeat (20) tick();
        check("sat_stall20", 32'(stall_cnt), 15);
        tick();
        check("sat_stall_hold", 32'(stall_cnt), 15);
        idle();
        ex_br_taken = 1;
        repeat (7) tick();
        check("sat_bubble14", 32'(bubble_cnt), 14);
        tick();
        check("sat_bubble_plus2", 32'(bubble_cnt), 15);
        tick();
        check("sat_bubble_hold", 32'(bubble_cnt), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
